// File: rtl/hilo_pkg.sv
// Shared Hi/Lo definitions: datapath width and divider FSM states.
// The hazard unit imports this package as well.
package hilo_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SIGN = 2'd2
  } hilo_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         dividend_bit,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] shifted;

  assign shifted = {rem, dividend_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // The difference is below the divisor, so the low W bits carry it exactly.
  assign rem_next = q_bit ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
endmodule

// File: rtl/hi_lo_unit.sv
// Hi/Lo register pair with a 34-cycle iterative divider (div/divu).
// Hi/Lo only change on ALU writes in IDLE or at the final SIGN edge.
module hi_lo_unit #(
  parameter int DATA_W = hilo_pkg::DATA_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 HiWrite,
  input  logic                 LoWrite,
  input  logic [DATA_W-1:0]    AluHi,
  input  logic [DATA_W-1:0]    AluLo,
  input  logic                 DivStart,
  input  logic                 DivSigned,
  input  logic [DATA_W-1:0]    DivA,
  input  logic [DATA_W-1:0]    DivB,
  output logic [DATA_W-1:0]    Hi_out,
  output logic [DATA_W-1:0]    Lo_out,
  output logic                 Busy,
  output logic                 DivDone,
  output hilo_pkg::hilo_state_t state_dbg
);
  import hilo_pkg::*;

  hilo_state_t       state, state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] hi, lo, a_raw, divisor, rem, dq;
  logic              neg_q, neg_r, div_zero, done;
  logic [DATA_W-1:0] rem_next, a_mag, b_mag;
  logic              q_bit, a_neg, b_neg;

  // Magnitudes; -2^31 negates to itself and is read as unsigned 0x80000000.
  assign a_neg = DivSigned & DivA[DATA_W-1];
  assign b_neg = DivSigned & DivB[DATA_W-1];
  assign a_mag = a_neg ? -DivA : DivA;
  assign b_mag = b_neg ? -DivB : DivB;

  div_step #(.W(DATA_W)) u_step (
    .rem          (rem),
    .divisor      (divisor),
    .dividend_bit (dq[DATA_W-1]),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (DivStart) state_next = DIV;
      DIV:     if (count == '0) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // dq holds the remaining dividend bits (MSB first) and collects quotient bits at the LSB.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi       <= '0;
      lo       <= '0;
      a_raw    <= '0;
      divisor  <= '0;
      rem      <= '0;
      dq       <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWrite) hi <= AluHi;
          if (LoWrite) lo <= AluLo;
          if (DivStart) begin
            a_raw    <= DivA;
            divisor  <= b_mag;
            dq       <= a_mag;
            rem      <= '0;
            count    <= CNT_W'(DATA_W - 1);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (DivB == '0);
          end
        end
        DIV: begin
          rem   <= rem_next;
          dq    <= {dq[DATA_W-2:0], q_bit};
          count <= count - 1'b1;
        end
        SIGN: begin
          lo   <= div_zero ? '1    : (neg_q ? -dq  : dq);
          hi   <= div_zero ? a_raw : (neg_r ? -rem : rem);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Hi_out    = hi;
  assign Lo_out    = lo;
  assign Busy      = (state != IDLE);
  assign DivDone   = done;
  assign state_dbg = state;
endmodule

// File: doc/hi_lo_unit.md
HI_LO_UNIT -- requirements
Module: hi_lo_unit

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; only 32 is required to work.
REQ-002 Clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 HiWrite  input  1  load Hi from AluHi (mult/madd/msub/mthi result from the ALU).
REQ-005 LoWrite  input  1  load Lo from AluLo (ALU 32-bit ALUResult low word).
REQ-006 AluHi  input  32  ALU Hi output.
REQ-007 AluLo  input  32  ALU low-word result.
REQ-008 DivStart  input  1  request a division; 1-cycle pulse from decode.
REQ-009 DivSigned  input  1  1 = div (two's-complement), 0 = divu; sampled with DivStart.
REQ-010 DivA  input  32  dividend; sampled with DivStart.
REQ-011 DivB  input  32  divisor; sampled with DivStart.
REQ-012 Hi_out  output  32  current Hi; drives the ALU Hi_in port.
REQ-013 Lo_out  output  32  current Lo; drives the ALU Lo_in port.
REQ-014 Busy  output  1  registered; high while a division is in flight; the pipeline stalls on it.
REQ-015 DivDone  output  1  registered 1-cycle pulse; high in the cycle Hi/Lo first show a division result.

Function
REQ-016 FSM states: IDLE, DIV, SIGN; Busy SHALL equal (state != IDLE).
REQ-017 IDLE: HiWrite/LoWrite SHALL update Hi/Lo on the same edge, independently; Hi_out/Lo_out show the new value the next cycle.
REQ-018 IDLE with DivStart=1: the edge SHALL latch operands, DivSigned and |operand| magnitudes, clear the partial remainder, load count=31 and enter DIV.
REQ-019 DIV: one restoring-division step per edge, MSB first (shift remainder left with the next dividend bit, subtract divisor if no borrow, shift quotient bit in); after the step at count=0 SHALL enter SIGN.
REQ-020 SIGN: one edge SHALL write Lo=quotient and Hi=remainder after sign fix-up, set DivDone for the next cycle and return to IDLE.
REQ-021 Latency: DivStart sampled at edge E0 -> Hi/Lo valid and DivDone=1 after edge E33; Busy high from after E0 through the cycle before E33's result appears.
REQ-022 Signed fix-up: quotient is negated when operand signs differ; remainder takes the sign of the dividend; the magnitude of -2^31 is handled as unsigned 0x80000000.
REQ-023 Divide by zero (either mode): Lo=0xFFFFFFFF, Hi=DivA; the full 34-cycle latency still applies.
REQ-024 Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
REQ-025 HiWrite, LoWrite and DivStart SHALL be ignored while Busy=1; DivStart and a write on the same IDLE edge: the write is applied, then the division overwrites both registers at completion.
REQ-026 Hi/Lo SHALL be readable unchanged throughout DIV; intermediate values never appear on Hi_out/Lo_out.

Reset
REQ-027 Reset=1 SHALL immediately force Hi=0, Lo=0, state=IDLE, Busy=0, DivDone=0, and clear the count and all operand and remainder registers.
REQ-028 Reset during DIV or SIGN SHALL abort the division with no result written; the first edge after release behaves as IDLE.

Structure
REQ-029 A shared package hilo_pkg SHALL hold DATA_W and the state enumeration (IDLE, DIV, SIGN), reusable by the hazard unit.
REQ-030 One sub-module, div_step, SHALL implement a combinational restoring step: remainder, divisor and dividend bit in; next remainder and quotient bit out.

Verification
REQ-031 Reset, then HiWrite=1/AluHi=0x12345678 and LoWrite=1/AluLo=0x9ABCDEF0 for one edge -> Hi_out=0x12345678, Lo_out=0x9ABCDEF0 the next cycle.
REQ-032 divu 100/7 -> Busy high; 34 cycles after start Lo=14, Hi=2, DivDone pulses exactly one cycle.
REQ-033 div -7/2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); div 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-034 div and divu 5/0 -> Lo=0xFFFFFFFF, Hi=5; HiWrite pulsed mid-division is ignored.
REQ-035 Assert Reset at cycle 10 of a divide -> Hi=Lo=0 and Busy=0 immediately; no DivDone follows; a new divu 9/3 then yields Lo=3, Hi=0.
